// File: rtl/wb_regfile_pkg.sv
// rtl/wb_regfile_pkg.sv - shared widths and constants for the write-back stage and register file
package wb_regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int CNT_W_DEF  = 32;
    localparam int NUM_REGS   = 32;

    // $0 is hard-wired to zero: writes to it are dropped and reads return 0
    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/wb_regfile_if.sv
// rtl/wb_regfile_if.sv - MEM/WB inputs, ID read ports and forwarding/debug outputs of the write-back stage
interface wb_regfile_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5,
    parameter int CNT_W  = 32
);

    logic              MemToReg_i;
    logic              RegWrite_i;
    logic [DATA_W-1:0] ReadData_i;
    logic [DATA_W-1:0] immed_i;
    logic [ADDR_W-1:0] RDaddr_i;
    logic [ADDR_W-1:0] RSaddr_i;
    logic [ADDR_W-1:0] RTaddr_i;
    logic [DATA_W-1:0] RSdata_o;
    logic [DATA_W-1:0] RTdata_o;
    logic [DATA_W-1:0] WBdata_o;
    logic              WBvalid_o;
    logic [CNT_W-1:0]  retired_o;

    // Pipeline side: drives MEM/WB values and ID read addresses
    modport master (
        output MemToReg_i, RegWrite_i, ReadData_i, immed_i,
        output RDaddr_i, RSaddr_i, RTaddr_i,
        input  RSdata_o, RTdata_o, WBdata_o, WBvalid_o, retired_o
    );

    // Register file side
    modport slave (
        input  MemToReg_i, RegWrite_i, ReadData_i, immed_i,
        input  RDaddr_i, RSaddr_i, RTaddr_i,
        output RSdata_o, RTdata_o, WBdata_o, WBvalid_o, retired_o
    );

endinterface

// File: rtl/wb_regfile_reg_array.sv
// rtl/wb_regfile_reg_array.sv - storage for registers 1..N-1 with async clear, one write port, two read ports
module reg_array
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_a_i,
    output logic [DATA_W-1:0] rdata_a_o,
    input  logic [ADDR_W-1:0] raddr_b_i,
    output logic [DATA_W-1:0] rdata_b_o
);

    localparam int NUM = 1 << ADDR_W;

    // Entry 0 has no storage at all; it is synthesised as a constant zero on the read side
    logic [DATA_W-1:0] mem_q [1:NUM-1];
    logic [DATA_W-1:0] mem_d [1:NUM-1];

    // Next-state of the array: hold, or load the single write port when enabled and not $0
    always_comb begin
        mem_d = mem_q;
        if (we_i && (waddr_i != ADDR_W'(REG_ZERO))) begin
            mem_d[waddr_i] = wdata_i;
        end
    end

    // Array storage; reset clears every entry immediately, independent of the clock
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            for (int i = 1; i < NUM; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            mem_q <= mem_d;
        end
    end

    // Read port A: combinational, $0 returns zero
    always_comb begin
        rdata_a_o = '0;
        if (raddr_a_i != ADDR_W'(REG_ZERO)) begin
            rdata_a_o = mem_q[raddr_a_i];
        end
    end

    // Read port B: combinational, $0 returns zero
    always_comb begin
        rdata_b_o = '0;
        if (raddr_b_i != ADDR_W'(REG_ZERO)) begin
            rdata_b_o = mem_q[raddr_b_i];
        end
    end

endmodule

// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - write-back mux, register file commit/read and retired-write counter (option: WB_REGFILE_BYPASS_EN)
module wb_regfile
    import wb_regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int CNT_W  = CNT_W_DEF
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    wb_regfile_if.slave bus
);

    logic [DATA_W-1:0] wb_data;
    logic              wb_valid;
    logic [DATA_W-1:0] rs_arr;
    logic [DATA_W-1:0] rt_arr;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic [CNT_W-1:0]  retired_q;
    logic [CNT_W-1:0]  retired_d;

    // Write-back select and commit qualifier; a write aimed at $0 is not a commit
    always_comb begin
        wb_data  = bus.MemToReg_i ? bus.ReadData_i : bus.immed_i;
        wb_valid = bus.RegWrite_i && (bus.RDaddr_i != ADDR_W'(REG_ZERO));
    end

    // Counter next value: one step per commit, wrapping naturally at 2^CNT_W
    always_comb begin
        retired_d = retired_q;
        if (wb_valid) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // Committed-write counter register
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            retired_q <= '0;
        end else begin
            retired_q <= retired_d;
        end
    end

    reg_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
    ) u_reg_array (
        .clk_i     (clk_i),
        .rst_n_i   (rst_n_i),
        .we_i      (wb_valid),
        .waddr_i   (bus.RDaddr_i),
        .wdata_i   (wb_data),
        .raddr_a_i (bus.RSaddr_i),
        .rdata_a_o (rs_arr),
        .raddr_b_i (bus.RTaddr_i),
        .rdata_b_o (rt_arr)
    );

`ifdef WB_REGFILE_BYPASS_EN
    // Write-through: an in-flight commit to the addressed register is visible in the same cycle.
    // Gated by reset so the read ports stay at zero while reset is held.
    always_comb begin
        rs_data = rs_arr;
        rt_data = rt_arr;
        if (rst_n_i && wb_valid && (bus.RSaddr_i == bus.RDaddr_i)) begin
            rs_data = wb_data;
        end
        if (rst_n_i && wb_valid && (bus.RTaddr_i == bus.RDaddr_i)) begin
            rt_data = wb_data;
        end
    end
`else
    // No write-through: reads show the array as it stands before the commit edge
    always_comb begin
        rs_data = rs_arr;
        rt_data = rt_arr;
    end
`endif

    assign bus.RSdata_o  = rs_data;
    assign bus.RTdata_o  = rt_data;
    assign bus.WBdata_o  = wb_data;
    assign bus.WBvalid_o = wb_valid;
    assign bus.retired_o = retired_q;

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - scoreboard bench for wb_regfile (expectations follow WB_REGFILE_BYPASS_EN)
module tb_wb_regfile;

`ifdef WB_REGFILE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    localparam int S_RS   = 0;
    localparam int S_RT   = 1;
    localparam int S_WB   = 2;
    localparam int S_WBV  = 3;
    localparam int S_RET  = 4;
    localparam int S_RET4 = 5;

    logic clk;
    logic rst_n;

    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) bus ();
    wb_regfile_if #(.DATA_W(32), .ADDR_W(5), .CNT_W(4))  bus4 ();

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(32)) dut (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus)
    );

    wb_regfile #(.DATA_W(32), .ADDR_W(5), .CNT_W(4)) dut4 (
        .clk_i   (clk),
        .rst_n_i (rst_n),
        .bus     (bus4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    string       q_tag [$];
    int          q_sel [$];
    logic [31:0] q_exp [$];
    int          n_tests = 0;
    int          n_fail  = 0;

    task automatic push(input string tag, input int sel, input logic [31:0] exp);
        q_tag.push_back(tag);
        q_sel.push_back(sel);
        q_exp.push_back(exp);
    endtask

    task automatic set_in(input logic m, input logic rw, input logic [31:0] rdat,
                          input logic [31:0] imm, input logic [4:0] rd,
                          input logic [4:0] rs, input logic [4:0] rt);
        @(posedge clk);
        #1;
        bus.MemToReg_i = m;
        bus.RegWrite_i = rw;
        bus.ReadData_i = rdat;
        bus.immed_i    = imm;
        bus.RDaddr_i   = rd;
        bus.RSaddr_i   = rs;
        bus.RTaddr_i   = rt;
    endtask

    // Monitor: compare every queued expectation against the outputs on the falling edge
    always @(negedge clk) begin
        while (q_sel.size() > 0) begin
            string       tag;
            int          sel;
            logic [31:0] exp;
            logic [31:0] act;
            tag = q_tag.pop_front();
            sel = q_sel.pop_front();
            exp = q_exp.pop_front();
            case (sel)
                S_RS:    act = bus.RSdata_o;
                S_RT:    act = bus.RTdata_o;
                S_WB:    act = bus.WBdata_o;
                S_WBV:   act = {31'd0, bus.WBvalid_o};
                S_RET:   act = bus.retired_o;
                default: act = {28'd0, bus4.retired_o};
            endcase
            n_tests++;
            if (act !== exp) begin
                n_fail++;
                $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
            end
        end
    end

    // Pre-edge value of register i during the fill loop when no write-through is present
    function automatic logic [31:0] old_val(input int i);
        case (i)
            3:       return 32'hCAFEF00D;
            8:       return 32'hDEADBEEF;
            9:       return 32'h00000055;
            default: return 32'h0;
        endcase
    endfunction

    initial begin
        rst_n = 1'b0;
        bus.MemToReg_i  = 1'b0; bus.RegWrite_i  = 1'b0; bus.ReadData_i  = '0; bus.immed_i  = '0;
        bus.RDaddr_i    = '0;   bus.RSaddr_i    = '0;   bus.RTaddr_i    = '0;
        bus4.MemToReg_i = 1'b0; bus4.RegWrite_i = 1'b0; bus4.ReadData_i = '0; bus4.immed_i = '0;
        bus4.RDaddr_i   = 5'd1; bus4.RSaddr_i   = '0;   bus4.RTaddr_i   = '0;

        // Reset held: every address reads 0, commits attempted meanwhile are lost
        for (int a = 0; a < 32; a++) begin
            set_in(1'b0, 1'b1, 32'h0, 32'h77, 5'd5, 5'(a), 5'(31 - a));
            push("rst_rs", S_RS, 32'h0);
            push("rst_rt", S_RT, 32'h0);
            push("rst_ret", S_RET, 32'h0);
            if (a == 0) begin
                push("rst_wbdata", S_WB, 32'h77);
                push("rst_wbvalid", S_WBV, 32'h1);
            end
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.RegWrite_i = 1'b0;
        bus.RSaddr_i   = 5'd5;
        push("rel_rs5", S_RS, 32'h0);
        push("rel_ret", S_RET, 32'h0);

        // Memory write-back to reg 8
        set_in(1'b1, 1'b1, 32'hDEADBEEF, 32'h1234, 5'd8, 5'd8, 5'd8);
        push("mem_wb", S_WB, 32'hDEADBEEF);
        push("mem_wbv", S_WBV, 32'h1);
        push("mem_pre_rs", S_RS, BYP ? 32'hDEADBEEF : 32'h0);
        push("mem_pre_ret", S_RET, 32'h0);
        set_in(1'b0, 1'b0, 32'hDEADBEEF, 32'h55, 5'd9, 5'd8, 5'd0);
        push("mem_rs8", S_RS, 32'hDEADBEEF);
        push("mem_rt0", S_RT, 32'h0);
        push("mem_ret", S_RET, 32'h1);
        push("nowr_wb", S_WB, 32'h55);
        push("nowr_wbv", S_WBV, 32'h0);

        // ALU write-back to reg 9, then to $0
        set_in(1'b0, 1'b1, 32'h0, 32'h55, 5'd9, 5'd9, 5'd9);
        push("alu_ret_pre", S_RET, 32'h1);
        set_in(1'b0, 1'b1, 32'h0, 32'h55, 5'd0, 5'd9, 5'd0);
        push("alu_rs9", S_RS, 32'h55);
        push("zero_rt0_pre", S_RT, 32'h0);
        push("zero_wbv", S_WBV, 32'h0);
        push("alu_ret", S_RET, 32'h2);
        set_in(1'b0, 1'b1, 32'h0, 32'h1, 5'd3, 5'd0, 5'd0);
        push("zero_rs0", S_RS, 32'h0);
        push("zero_rt0", S_RT, 32'h0);
        push("zero_ret", S_RET, 32'h2);

        // Same-cycle hazard on reg 3 (holds 0x1)
        set_in(1'b0, 1'b1, 32'h0, 32'hCAFEF00D, 5'd3, 5'd3, 5'd3);
        push("haz_pre_rs", S_RS, BYP ? 32'hCAFEF00D : 32'h1);
        push("haz_pre_rt", S_RT, BYP ? 32'hCAFEF00D : 32'h1);
        push("haz_ret", S_RET, 32'h3);
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd3, 5'd3, 5'd3);
        push("haz_post_rs", S_RS, 32'hCAFEF00D);
        push("haz_post_rt", S_RT, 32'hCAFEF00D);
        push("haz_post_ret", S_RET, 32'h4);
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd9, 5'd8);
        push("keep_rs9", S_RS, 32'h55);
        push("keep_rt8", S_RT, 32'hDEADBEEF);

        // Fill regs 1..31 with their own index
        for (int i = 1; i < 32; i++) begin
            set_in(1'b0, 1'b1, 32'h0, 32'(i), 5'(i), 5'(i - 1), 5'(i));
            push("fill_rs", S_RS, 32'(i - 1));
            push("fill_rt", S_RT, BYP ? 32'(i) : old_val(i));
            push("fill_ret", S_RET, 32'(4 + i - 1));
        end
        set_in(1'b0, 1'b0, 32'h0, 32'h0, 5'd0, 5'd31, 5'd3);
        push("fill_rs31", S_RS, 32'd31);
        push("fill_rt3", S_RT, 32'd3);
        push("fill_ret_end", S_RET, 32'd35);

        // Reset mid-run between edges: clears at once, with no clock edge in between
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        bus.RegWrite_i = 1'b1;
        bus.immed_i    = 32'hBAD;
        bus.RDaddr_i   = 5'd7;
        bus.RSaddr_i   = 5'd7;
        bus.RTaddr_i   = 5'd31;
        push("mid_rs7", S_RS, 32'h0);
        push("mid_rt31", S_RT, 32'h0);
        push("mid_ret", S_RET, 32'h0);
        for (int j = 0; j < 3; j++) begin
            set_in(1'b0, 1'b1, 32'h0, 32'hBAD, 5'd7, 5'(j * 10 + 1), 5'(j * 10 + 2));
            push("mid_hold_rs", S_RS, 32'h0);
            push("mid_hold_rt", S_RT, 32'h0);
        end
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        bus.RegWrite_i = 1'b0;
        bus.RSaddr_i   = 5'd7;
        bus.RTaddr_i   = 5'd1;
        push("mid_lost_rs7", S_RS, 32'h0);
        push("mid_rel_rt1", S_RT, 32'h0);
        push("mid_rel_ret", S_RET, 32'h0);

        // Counter wrap on the 4-bit instance: 17 commits leave 1
        for (int k = 0; k < 17; k++) begin
            @(posedge clk);
            #1;
            bus4.RegWrite_i = 1'b1;
            push("wrap_cnt", S_RET4, 32'(k % 16));
        end
        @(posedge clk);
        #1;
        bus4.RegWrite_i = 1'b0;
        push("wrap_17", S_RET4, 32'h1);

        for (int k = 0; k < 10 && q_sel.size() != 0; k++) begin
            @(negedge clk);
        end
        #1;
        if (q_sel.size() != 0) begin
            n_fail++;
            $display("FAIL drain: %0d expectations left, expected 0", q_sel.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
